// File: rtl/sg_env_driver_if.sv
// rtl/sg_env_driver_if.sv - stimulus, observation and table-programming bundle for sg_env_driver
interface sg_env_driver_if #(
    parameter int N_IN       = 4,
    parameter int N_OUT      = 4,
    parameter int STATE_BITS = 4,
    parameter int N_TR       = 32
);
    localparam int AW = $clog2(N_TR);
    localparam int SW = $clog2(N_IN + N_OUT);

    logic                  run;
    logic [N_IN-1:0]       ena;
    logic [N_OUT-1:0]      out_obs;
    logic                  prog_we;
    logic [AW-1:0]         prog_addr;
    logic                  prog_valid;
    logic [STATE_BITS-1:0] prog_from;
    logic [SW-1:0]         prog_sig;
    logic                  prog_dir;
    logic [STATE_BITS-1:0] prog_to;
    logic [N_IN-1:0]       in_drv;
    logic [STATE_BITS-1:0] state;
    logic                  fired;
    logic                  refused;
    logic                  error;
    logic [1:0]            err_code;
    logic                  stall;

    modport master (
        output run, ena, out_obs, prog_we, prog_addr, prog_valid, prog_from, prog_sig, prog_dir, prog_to,
        input  in_drv, state, fired, refused, error, err_code, stall
    );
    modport slave (
        input  run, ena, out_obs, prog_we, prog_addr, prog_valid, prog_from, prog_sig, prog_dir, prog_to,
        output in_drv, state, fired, refused, error, err_code, stall
    );
endinterface

// File: rtl/sg_env_driver.sv
// rtl/sg_env_driver.sv - state-graph environment driver: fires allowed input edges, checks output edges
module sg_env_driver #(
    parameter int N_IN       = 4,
    parameter int N_OUT      = 4,
    parameter int STATE_BITS = 4,
    parameter int N_TR       = 32,
    parameter int INIT_STATE = 0,
    parameter int INIT_IN    = 0,
    parameter int INIT_OUT   = 0,
    parameter int STALL_MAX  = 255
) (
    input logic             clk,
    input logic             reset,
    sg_env_driver_if.slave  bus
);
    localparam int SW = $clog2(N_IN + N_OUT);
    localparam int CW = $clog2(STALL_MAX + 1);

    logic [N_TR-1:0]       tab_valid;
    logic [STATE_BITS-1:0] tab_from [N_TR];
    logic [SW-1:0]         tab_sig  [N_TR];
    logic                  tab_dir  [N_TR];
    logic [STATE_BITS-1:0] tab_to   [N_TR];

    logic [STATE_BITS-1:0] state_q;
    logic [N_IN-1:0]       in_q;
    logic [N_OUT-1:0]      out_q;
    logic                  fired_q, refused_q, error_q;
    logic [1:0]            code_q;
    logic [CW-1:0]         idle_q;

    logic [N_OUT-1:0]      delta;
    logic [SW-1:0]         look_sig;
    logic                  look_dir;
    logic                  hit;
    logic [STATE_BITS-1:0] hit_to;
    logic                  active, take_out, take_in;

    // One shared lookup: an output edge has priority, otherwise the requested input edge is searched.
    always_comb begin
        delta    = bus.out_obs ^ out_q;
        look_sig = '0;
        look_dir = 1'b0;
        for (int j = 0; j < N_OUT; j++) begin
            if (delta[j]) begin
                look_sig = SW'(N_IN + j);
                look_dir = bus.out_obs[j];
            end
        end
        if (delta == '0) begin
            for (int i = 0; i < N_IN; i++) begin
                if (bus.ena[i]) begin
                    look_sig = SW'(i);
                    look_dir = ~in_q[i];
                end
            end
        end
        hit    = 1'b0;
        hit_to = '0;
        for (int e = N_TR - 1; e >= 0; e--) begin
            if (tab_valid[e] && tab_from[e] == state_q && tab_sig[e] == look_sig && tab_dir[e] == look_dir) begin
                hit    = 1'b1;
                hit_to = tab_to[e];
            end
        end
        active   = bus.run && !error_q;
        take_out = active && $onehot(delta) && hit;
        take_in  = active && (delta == '0) && $onehot(bus.ena) && hit;
    end

    always_ff @(posedge clk) begin
        if (bus.prog_we && !bus.run) begin
            tab_from[bus.prog_addr] <= bus.prog_from;
            tab_sig[bus.prog_addr]  <= bus.prog_sig;
            tab_dir[bus.prog_addr]  <= bus.prog_dir;
            tab_to[bus.prog_addr]   <= bus.prog_to;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tab_valid <= '0;
            state_q   <= STATE_BITS'(INIT_STATE);
            in_q      <= N_IN'(INIT_IN);
            out_q     <= N_OUT'(INIT_OUT);
            fired_q   <= 1'b0;
            refused_q <= 1'b0;
            error_q   <= 1'b0;
            code_q    <= 2'd0;
            idle_q    <= '0;
        end else begin
            out_q     <= bus.out_obs;
            fired_q   <= 1'b0;
            refused_q <= 1'b0;
            if (bus.prog_we && !bus.run)
                tab_valid[bus.prog_addr] <= bus.prog_valid;
            if (active) begin
                if (delta != '0 && !$onehot(delta)) begin
                    error_q <= 1'b1;
                    code_q  <= 2'd2;
                end else if (delta != '0) begin
                    refused_q <= (bus.ena != '0);
                    if (hit) begin
                        state_q <= hit_to;
                    end else begin
                        error_q <= 1'b1;
                        code_q  <= 2'd1;
                    end
                end else if (!$onehot0(bus.ena)) begin
                    error_q <= 1'b1;
                    code_q  <= 2'd3;
                end else if (bus.ena != '0) begin
                    if (hit) begin
                        in_q    <= in_q ^ bus.ena;
                        state_q <= hit_to;
                        fired_q <= 1'b1;
                    end else begin
                        refused_q <= 1'b1;
                    end
                end
            end
            // Any taken transition, self-loops included, counts as progress.
            if (!bus.run || take_out || take_in)
                idle_q <= '0;
            else if (idle_q != CW'(STALL_MAX))
                idle_q <= idle_q + 1'b1;
        end
    end

    assign bus.in_drv   = in_q;
    assign bus.state    = state_q;
    assign bus.fired    = fired_q;
    assign bus.refused  = refused_q;
    assign bus.error    = error_q;
    assign bus.err_code = code_q;
    assign bus.stall    = (idle_q == CW'(STALL_MAX));
endmodule

// File: tb/tb_sg_env_driver.sv
// tb/tb_sg_env_driver.sv - directed 4-phase handshake walk against a transaction-level graph model
module tb_sg_env_driver;
    localparam int SMAX = 8;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    sg_env_driver_if #(.N_IN(4), .N_OUT(4), .STATE_BITS(4), .N_TR(32)) bus ();

    sg_env_driver #(
        .N_IN(4), .N_OUT(4), .STATE_BITS(4), .N_TR(32),
        .INIT_STATE(0), .INIT_IN(0), .INIT_OUT(0), .STALL_MAX(SMAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct { bit v; int from; int sig; int dir; int to; } ent_t;
    typedef struct { int state; int in_bits[4]; int outq[4]; bit err; int code; bit fired; bit refused; int idle; } ms_t;

    ent_t m_tab [32];
    ms_t  m;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ms_t m_init();
        ms_t r;
        r.state = 0; r.err = 0; r.code = 0; r.fired = 0; r.refused = 0; r.idle = 0;
        for (int k = 0; k < 4; k++) begin r.in_bits[k] = 0; r.outq[k] = 0; end
        return r;
    endfunction

    function automatic bit find(input int st, input int sig, input int dir, output int to);
        to = 0;
        for (int e = 0; e < 32; e++)
            if (m_tab[e].v && m_tab[e].from == st && m_tab[e].sig == sig && m_tab[e].dir == dir) begin
                to = m_tab[e].to;
                return 1'b1;
            end
        return 1'b0;
    endfunction

    function automatic ms_t step(input ms_t c, input bit run, input logic [3:0] ena, input logic [3:0] obs);
        ms_t n = c;
        int changed = 0, nreq = 0, j = 0, i = 0, to;
        bit moved = 0;
        n.fired = 0; n.refused = 0;
        for (int k = 0; k < 4; k++) begin
            if (int'(obs[k]) != c.outq[k]) begin changed++; j = k; end
            if (ena[k]) begin nreq++; i = k; end
            n.outq[k] = int'(obs[k]);
        end
        if (!run) begin n.idle = 0; return n; end
        if (!c.err) begin
            if (changed > 1) begin n.err = 1; n.code = 2; end
            else if (changed == 1) begin
                if (nreq > 0) n.refused = 1;
                if (find(c.state, 4 + j, int'(obs[j]), to)) begin n.state = to; moved = 1; end
                else begin n.err = 1; n.code = 1; end
            end else if (nreq > 1) begin n.err = 1; n.code = 3; end
            else if (nreq == 1) begin
                if (find(c.state, i, 1 - c.in_bits[i], to)) begin
                    n.in_bits[i] = 1 - c.in_bits[i]; n.state = to; n.fired = 1; moved = 1;
                end else n.refused = 1;
            end
        end
        n.idle = moved ? 0 : ((c.idle < SMAX) ? c.idle + 1 : SMAX);
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m <= m_init();
            for (int e = 0; e < 32; e++) m_tab[e].v <= 1'b0;
        end else begin
            m <= step(m, bus.run, bus.ena, bus.out_obs);
            if (!bus.run && bus.prog_we)
                m_tab[bus.prog_addr] <= '{bus.prog_valid, int'(bus.prog_from), int'(bus.prog_sig),
                                          int'(bus.prog_dir), int'(bus.prog_to)};
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            int exp_in;
            exp_in = 0;
            for (int k = 0; k < 4; k++) exp_in += m.in_bits[k] << k;
            chk("m_state", int'(bus.state), m.state);
            chk("m_in_drv", int'(bus.in_drv), exp_in);
            chk("m_fired", int'(bus.fired), int'(m.fired));
            chk("m_refused", int'(bus.refused), int'(m.refused));
            chk("m_error", int'(bus.error), int'(m.err));
            chk("m_err_code", int'(bus.err_code), m.code);
            chk("m_stall", int'(bus.stall), int'(m.idle == SMAX));
        end
    end

    task automatic prog(input int addr, input int from, input int sig, input int dir, input int to);
        @(negedge clk);
        bus.prog_we = 1; bus.prog_addr = 5'(addr); bus.prog_valid = 1;
        bus.prog_from = 4'(from); bus.prog_sig = 3'(sig); bus.prog_dir = 1'(dir); bus.prog_to = 4'(to);
        @(negedge clk);
        bus.prog_we = 0;
    endtask

    task automatic pulse_ena(input logic [3:0] v);
        bus.ena = v;
        @(negedge clk);
        bus.ena = 4'd0;
    endtask

    initial begin
        reset = 1; bus.run = 0; bus.ena = 0; bus.out_obs = 0;
        bus.prog_we = 0; bus.prog_addr = 0; bus.prog_valid = 0; bus.prog_from = 0;
        bus.prog_sig = 0; bus.prog_dir = 0; bus.prog_to = 0;
        repeat (2) @(negedge clk);
        chk("rst_state", int'(bus.state), 0);
        chk("rst_in_drv", int'(bus.in_drv), 0);
        chk("rst_error", int'(bus.error), 0);
        chk("rst_stall", int'(bus.stall), 0);
        reset = 0;

        prog(0, 0, 0, 1, 1);
        prog(1, 1, 4, 1, 2);
        prog(2, 2, 0, 0, 3);
        prog(3, 3, 4, 0, 0);
        prog(5, 0, 0, 1, 7);           // shadowed by entry 0
        bus.run = 1;
        bus.prog_we = 1; bus.prog_addr = 6; bus.prog_valid = 1;
        bus.prog_from = 1; bus.prog_sig = 0; bus.prog_dir = 0; bus.prog_to = 5;
        @(negedge clk);
        bus.prog_we = 0;

        pulse_ena(4'b0001);
        chk("req_rise_state", int'(bus.state), 1);
        chk("req_rise_in", int'(bus.in_drv), 1);
        chk("req_rise_fired", int'(bus.fired), 1);
        @(negedge clk);
        chk("fired_pulse_end", int'(bus.fired), 0);

        pulse_ena(4'b0001);
        chk("refuse_flag", int'(bus.refused), 1);
        chk("refuse_state", int'(bus.state), 1);
        chk("refuse_err", int'(bus.error), 0);

        bus.out_obs = 4'b0001;
        pulse_ena(4'b0001);
        chk("ack_state", int'(bus.state), 2);
        chk("ack_refused", int'(bus.refused), 1);
        chk("ack_in_kept", int'(bus.in_drv), 1);

        pulse_ena(4'b0001);
        chk("req_fall_state", int'(bus.state), 3);
        chk("req_fall_in", int'(bus.in_drv), 0);
        bus.out_obs = 4'b0000;
        @(negedge clk);
        chk("ack_fall_state", int'(bus.state), 0);

        pulse_ena(4'b0001);
        bus.out_obs = 4'b0001;
        @(negedge clk);
        chk("walk2_state", int'(bus.state), 2);
        bus.out_obs = 4'b0000;
        @(negedge clk);
        chk("bad_edge_err", int'(bus.error), 1);
        chk("bad_edge_code", int'(bus.err_code), 1);
        chk("bad_edge_state", int'(bus.state), 2);
        pulse_ena(4'b0001);
        chk("halt_in", int'(bus.in_drv), 1);
        chk("halt_fired", int'(bus.fired), 0);
        chk("halt_refused", int'(bus.refused), 0);

        #2 reset = 1;
        #1;
        chk("async_rst_state", int'(bus.state), 0);
        chk("async_rst_in", int'(bus.in_drv), 0);
        chk("async_rst_err", int'(bus.error), 0);
        @(negedge clk);
        reset = 0;
        pulse_ena(4'b0001);
        chk("table_cleared", int'(bus.refused), 1);

        bus.run = 0;
        prog(0, 0, 1, 1, 0);           // self-loop on input 1
        prog(1, 0, 0, 1, 1);
        bus.run = 1;
        repeat (7) @(negedge clk);
        chk("stall_before", int'(bus.stall), 0);
        @(negedge clk);
        chk("stall_at_max", int'(bus.stall), 1);
        pulse_ena(4'b0010);
        chk("self_loop_fired", int'(bus.fired), 1);
        chk("self_loop_state", int'(bus.state), 0);
        chk("self_loop_in", int'(bus.in_drv), 2);
        chk("stall_cleared", int'(bus.stall), 0);

        bus.out_obs = 4'b0011;
        @(negedge clk);
        chk("multi_edge_code", int'(bus.err_code), 2);

        reset = 1; bus.out_obs = 4'b0000;
        @(negedge clk);
        reset = 0;
        pulse_ena(4'b0011);
        chk("ena_multi_err", int'(bus.error), 1);
        chk("ena_multi_code", int'(bus.err_code), 3);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sg_env_driver.md
Name: sg_env_driver

Overview:
- Synthesizable environment driver for a state-graph-derived circuit model.
- Holds a programmable state-graph transition table.
- Drives the circuit's input signals, firing only transitions the graph allows in the current state.
- Tracks circuit output edges against the same graph and flags any output edge the graph does not allow.
- Sits beside the circuit under test in formal and simulation harnesses, as the stimulus end of the checking flow.

Parameters:
N_IN, 4, number of circuit inputs driven by this block
N_OUT, 4, number of circuit outputs observed
STATE_BITS, 4, width of the state-graph state encoding
N_TR, 32, transition table depth
INIT_STATE, 0, state after reset
INIT_IN, 0, value of in_drv after reset
INIT_OUT, 0, assumed value of out_obs at reset (edge-detect baseline)
STALL_MAX, 255, idle cycles in RUN before stall asserts

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
run  in  1  1 = walk the graph; 0 = hold, table writable
ena  in  N_IN  fire request; bit i = toggle input i if allowed
out_obs  in  N_OUT  circuit outputs, sampled each clk
prog_we  in  1  table write strobe, honoured only when run=0
prog_addr  in  clog2(N_TR)  table entry index
prog_valid  in  1  entry valid bit
prog_from  in  STATE_BITS  source state
prog_sig  in  clog2(N_IN+N_OUT)  signal index: 0..N_IN-1 inputs, N_IN.. outputs
prog_dir  in  1  1 = rise, 0 = fall
prog_to  in  STATE_BITS  destination state
in_drv  out  N_IN  registered circuit input values
state  out  STATE_BITS  current graph state
fired  out  1  one-cycle pulse: input transition taken
refused  out  1  one-cycle pulse: ena request not taken
error  out  1  sticky violation flag
err_code  out  2  0 none, 1 unexpected output edge, 2 multiple output edges, 3 ena not onehot0
stall  out  1  no transition for STALL_MAX cycles in RUN

Behaviour:
- Reset (async, immediate):
  - state=INIT_STATE, in_drv=INIT_IN, out_q=INIT_OUT.
  - All table valid bits cleared.
  - fired=refused=error=stall=0, err_code=0, idle counter=0.
  - Reset mid-run abandons the current walk with no partial update.
- Programming: when run=0 and prog_we=1, the entry at prog_addr is written on the clk edge. prog_we while run=1 is ignored.
- Edge detect: delta = out_obs ^ out_q; out_q <= out_obs every cycle, including when run=0 and when halted.
- Lookup is combinational over all entries. Match requires valid, from==state, sig==index, and dir==new signal value. Lowest matching index wins.
- Halted means error=1. While halted, state and in_drv freeze, fired/refused stay 0, and only reset clears the halt.
- Each cycle with run=1 and not halted, in priority order:
  1. popcount(delta) > 1: error=1, err_code=2.
  2. popcount(delta) == 1 on output j: matching entry → state<=to. No match → error=1, err_code=1, state unchanged. Any nonzero ena in the same cycle is dropped with refused=1.
  3. delta == 0 and ena not onehot0: error=1, err_code=3.
  4. delta == 0 and ena one-hot on bit i: matching entry for input i, dir = ~in_drv[i] → in_drv[i] toggles, state<=to, fired=1 next cycle. No match → refused=1, no other change (not an error).
  5. Otherwise idle.
- Latency: ena sampled at edge k; in_drv, state and fired update at edge k, visible in cycle k+1.
- Stall counter:
  - Increments in RUN when no state change occurs; saturates at STALL_MAX.
  - stall=1 while counter==STALL_MAX.
  - Clears on any state change or when run=0.
- run=0: no graph walk and no error checking; table writes allowed.
- Self-loop entries (to==from) are legal: fired pulses, state is unchanged, stall counter clears.

Test Plan:
- 4-phase table (req=in0, ack=out0; 0-req+→1, 1-ack+→2, 2-req-→3, 3-ack-→0): ena=0001 in state 0 → in_drv=0001, state=1, fired=1 one cycle later.
- State 1 with ena=0001 (req- not allowed) → refused=1, in_drv and state unchanged, error=0.
- State 1, out_obs 0→1 → state=2. Then out_obs 1→0 in state 2 → error=1, err_code=1, state stays 2, later ena ignored.
- out_obs bits 0 and 1 change in the same cycle → err_code=2. Separate run: ena=0011 → err_code=3.
- ena=0001 in the same cycle as a legal output edge → output transition taken, refused=1, in_drv unchanged.
- STALL_MAX=8, run=1 with no activity → stall=1 after 8 cycles; a legal ena clears it. Reset asserted mid-walk → all outputs and the table return to reset values immediately.
